// File: rtl/nand_bch_pkg.sv
// nand_bch_pkg: shared sizing helpers and state type for the BCH sector datapath.
package nand_bch_pkg;

    typedef enum logic {IDLE, STREAM} state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int clog2_min1(input int x);
        return (x < 2) ? 1 : $clog2(x);
    endfunction

    function automatic int words_of(input int frame_bits, input int bits);
        return ceil_div(frame_bits, bits);
    endfunction

    function automatic int pad_of(input int frame_bits, input int bits);
        return ceil_div(frame_bits, bits) * bits - frame_bits;
    endfunction

endpackage

// File: rtl/frame_shift_reg.sv
// frame_shift_reg: active frame register with parallel load, BITS-wide left shift and MSB word tap.
module frame_shift_reg #(
    parameter int TOT  = 8,
    parameter int BITS = 8
) (
    input  logic            clk_in,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            load,
    input  logic            shift,
    input  logic [TOT-1:0]  load_data,
    output logic [BITS-1:0] word
);

    logic [TOT-1:0] q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else if (clr) q <= '0;
        else if (load) q <= load_data;
        else if (shift) q <= q << BITS;
    end

    assign word = q[TOT-1 -: BITS];

endmodule

// File: rtl/frame_serializer.sv
// frame_serializer: double-buffered frame-to-word serializer, MSB first, with first/last framing.
// Defining FRAME_SERIALIZER_WORD_IDX_EN adds the out_idx word-index output.
module frame_serializer
    import nand_bch_pkg::*;
#(
    parameter int  FRAME_BITS = 4348,
    parameter int  BITS       = 8,
    localparam int WORDS      = words_of(FRAME_BITS, BITS),
    localparam int CW         = clog2_min1(WORDS)
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic [FRAME_BITS-1:0] load_data,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic                  abort,
    output logic [BITS-1:0]       out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_first,
`ifdef FRAME_SERIALIZER_WORD_IDX_EN
    output logic [CW-1:0]         out_idx,
`endif
    output logic                  out_last
);

    localparam int TOT = FRAME_BITS + pad_of(FRAME_BITS, BITS);

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [TOT-1:0] shadow, padded;
    logic           shadow_full, load_fire, word_fire, last_fire, take;

    assign padded     = TOT'(load_data);
    assign load_ready = !shadow_full && !abort;
    assign load_fire  = load_valid && load_ready;
    assign out_valid  = state == STREAM;
    assign word_fire  = out_valid && out_ready;
    assign last_fire  = word_fire && cnt == CW'(WORDS - 1);
    // A frame enters the active register from IDLE, or as the current frame's last word leaves
    assign take = (!out_valid && load_fire) || (last_fire && (shadow_full || load_fire));

`ifdef FRAME_SERIALIZER_WORD_IDX_EN
    assign out_idx = cnt;
`endif

    frame_shift_reg #(.TOT(TOT), .BITS(BITS)) u_active (
        .clk_in,
        .rst_n,
        .clr(abort),
        .load(take),
        .shift(word_fire),
        .load_data(shadow_full ? shadow : padded),
        .word(out_data)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            shadow      <= '0;
            shadow_full <= 1'b0;
            out_first   <= 1'b0;
            out_last    <= 1'b0;
        end else if (abort) begin
            state       <= IDLE;
            cnt         <= '0;
            shadow_full <= 1'b0;
            out_first   <= 1'b0;
            out_last    <= 1'b0;
        end else begin
            if (load_fire && out_valid && !last_fire) begin
                shadow      <= padded;
                shadow_full <= 1'b1;
            end else if (last_fire) begin
                shadow_full <= 1'b0;
            end
            if (take) begin
                state     <= STREAM;
                cnt       <= '0;
                out_first <= 1'b1;
                out_last  <= WORDS == 1;
            end else if (last_fire) begin
                state     <= IDLE;
                cnt       <= '0;
                out_first <= 1'b0;
                out_last  <= 1'b0;
            end else if (word_fire) begin
                cnt       <= cnt + 1'b1;
                out_first <= 1'b0;
                out_last  <= cnt == CW'(WORDS - 2);
            end
        end
    end

endmodule

// File: tb/tb_frame_serializer.sv
// tb_frame_serializer: randomized and directed checks of frame_serializer against a word-queue model.
module tb_frame_serializer;

    localparam int FB  = 20;
    localparam int B   = 8;
    localparam int W   = 3;
    localparam int LFB = 4348;
    localparam int LW  = 544;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk_in = ~clk_in;

    logic [FB-1:0] s_load_data = '0;
    logic          s_load_valid = 1'b0, s_abort = 1'b0, s_out_ready = 1'b0;
    logic          s_load_ready, s_out_valid, s_out_first, s_out_last;
    logic [B-1:0]  s_out_data;

    logic [LFB-1:0] l_load_data = '0;
    logic           l_load_valid = 1'b0, l_abort = 1'b0, l_out_ready = 1'b0;
    logic           l_load_ready, l_out_valid, l_out_first, l_out_last;
    logic [7:0]     l_out_data;

    frame_serializer #(.FRAME_BITS(FB), .BITS(B)) dut_s (
        .clk_in(clk_in), .rst_n(rst_n), .load_data(s_load_data), .load_valid(s_load_valid),
        .load_ready(s_load_ready), .abort(s_abort), .out_data(s_out_data), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_first(s_out_first), .out_last(s_out_last)
    );

    frame_serializer dut_l (
        .clk_in(clk_in), .rst_n(rst_n), .load_data(l_load_data), .load_valid(l_load_valid),
        .load_ready(l_load_ready), .abort(l_abort), .out_data(l_out_data), .out_valid(l_out_valid),
        .out_ready(l_out_ready), .out_first(l_out_first), .out_last(l_out_last)
    );

    int checks = 0;
    int passed = 0;

    // Model: the words still owed to the consumer, each tagged with its framing flags
    typedef struct {logic [7:0] d; logic f; logic l;} wd_t;
    wd_t q[$];

    function automatic int in_flight();
        return (q.size() + W - 1) / W;
    endfunction

    function automatic logic exp_ready();
        return !s_abort && in_flight() < 2;
    endfunction

    function automatic logic [11:0] exp_vec();
        return (q.size() > 0) ? {1'b1, q[0].d, q[0].f, q[0].l, exp_ready()}
                              : {1'b0, 8'h00, 1'b0, 1'b0, exp_ready()};
    endfunction

    function automatic logic [11:0] dut_vec();
        return {s_out_valid, s_out_valid ? s_out_data : 8'h00, s_out_first, s_out_last, s_load_ready};
    endfunction

    task automatic push_frame(input logic [FB-1:0] fr);
        logic [W*B-1:0] p;
        p = (W*B)'(fr);
        for (int k = 0; k < W; k++) q.push_back('{8'(p >> (B * (W - 1 - k))), k == 0, k == W - 1});
    endtask

    task automatic tick();
        logic lf, wf;
        lf = s_load_valid && exp_ready();
        wf = q.size() > 0 && s_out_ready;
        @(posedge clk_in);
        if (s_abort) q.delete();
        else begin
            if (wf) void'(q.pop_front());
            if (lf) push_frame(s_load_data);
        end
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk_in);
        #1;
        checks++;
        if ({s_out_valid, s_out_data, s_out_first, s_out_last, s_load_ready} !== 12'b0_00000000_0_0_1)
            $display("FAIL reset_small: got %b want 000000000001", {s_out_valid, s_out_data, s_out_first, s_out_last, s_load_ready});
        else passed++;
        checks++;
        if ({l_out_valid, l_out_data, l_out_first, l_out_last, l_load_ready} !== 12'b0_00000000_0_0_1)
            $display("FAIL reset_large: got %b want 000000000001", {l_out_valid, l_out_data, l_out_first, l_out_last, l_load_ready});
        else passed++;
        rst_n = 1'b1;
        q.delete();
    endtask

    task automatic test_single();
        logic [23:0] got = '0;
        s_out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            s_load_valid = c == 0;
            s_load_data = 20'hABCDE;
            #1;
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL single c%0d: got %h want %h", c, dut_vec(), exp_vec());
            else passed++;
            if (s_out_valid) got = {got[15:0], s_out_data};
            tick();
        end
        checks++;
        if (got !== 24'h0ABCDE) $display("FAIL single_words: got %h want 0abcde", got);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [FB-1:0] fr [2] = '{20'hABCDE, 20'h12345};
        logic [47:0]   got = '0;
        int            idx = 0;
        logic          acc;
        s_out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            s_load_valid = idx < 2;
            s_load_data = fr[idx % 2];
            #1;
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL b2b c%0d: got %h want %h", c, dut_vec(), exp_vec());
            else passed++;
            if (s_out_valid) got = {got[39:0], s_out_data};
            acc = s_load_valid && exp_ready();
            tick();
            if (acc) idx++;
        end
        s_load_valid = 1'b0;
        checks++;
        if (got !== 48'h0ABCDE012345) $display("FAIL b2b_words: got %h want 0abcde012345", got);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [23:0] got = '0;
        for (int c = 0; c < 9; c++) begin
            s_load_valid = c == 0;
            s_load_data = 20'hABCDE;
            s_out_ready = !(c >= 2 && c <= 5);
            #1;
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL backpressure c%0d: got %h want %h", c, dut_vec(), exp_vec());
            else passed++;
            if (s_out_valid && s_out_ready) got = {got[15:0], s_out_data};
            tick();
        end
        checks++;
        if (got !== 24'h0ABCDE) $display("FAIL backpressure_words: got %h want 0abcde", got);
        else passed++;
    endtask

    task automatic test_abort();
        logic [FB-1:0] fr [4] = '{20'hABCDE, 20'h12345, 20'hFFFFF, 20'h5A5A5};
        s_out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            s_abort = c == 2;
            s_load_valid = c <= 3;
            s_load_data = fr[c % 4];
            #1;
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL abort c%0d: got %h want %h", c, dut_vec(), exp_vec());
            else passed++;
            tick();
        end
        s_abort = 1'b0;
        s_load_valid = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 410; c++) begin
            s_load_valid = c < 400 && $urandom_range(0, 1) == 1;
            s_load_data = FB'($urandom);
            s_out_ready = c >= 400 || $urandom_range(0, 3) != 0;
            s_abort = c < 400 && $urandom_range(0, 31) == 0;
            #1;
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL random c%0d: got %h want %h", c, dut_vec(), exp_vec());
            else passed++;
            tick();
        end
        s_abort = 1'b0;
        s_load_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        s_out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            s_load_valid = 1'b1;
            s_load_data = c == 0 ? 20'hABCDE : 20'h12345;
            #1;
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL async_pre c%0d: got %h want %h", c, dut_vec(), exp_vec());
            else passed++;
            tick();
        end
        s_load_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_out_valid, s_out_data, s_out_first, s_out_last, s_load_ready} !== 12'b0_00000000_0_0_1)
            $display("FAIL async_reset: got %b want 000000000001", {s_out_valid, s_out_data, s_out_first, s_out_last, s_load_ready});
        else passed++;
        q.delete();
        @(posedge clk_in);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL async_post c%0d: got %h want %h", c, dut_vec(), exp_vec());
            else passed++;
            tick();
        end
    endtask

    task automatic test_default_sector();
        logic [LW*8-1:0] p;
        logic [LFB-1:0]  fr;
        logic [10:0]     exp;
        fr = {{4096{1'b1}}, {252{1'b0}}};
        p = (LW*8)'(fr);
        l_load_data = fr;
        l_load_valid = 1'b1;
        l_out_ready = 1'b1;
        #1;
        checks++;
        if (l_load_ready !== 1'b1 || l_out_valid !== 1'b0)
            $display("FAIL sector_accept: got rdy=%b v=%b want rdy=1 v=0", l_load_ready, l_out_valid);
        else passed++;
        @(posedge clk_in);
        #1;
        l_load_valid = 1'b0;
        for (int k = 0; k < LW; k++) begin
            exp = {1'b1, 8'(p >> (8 * (LW - 1 - k))), k == 0, k == LW - 1};
            checks++;
            if ({l_out_valid, l_out_data, l_out_first, l_out_last} !== exp)
                $display("FAIL sector_word%0d: got %h want %h", k, {l_out_valid, l_out_data, l_out_first, l_out_last}, exp);
            else passed++;
            if (k == 0) begin
                checks++;
                if (l_out_data !== 8'h0F) $display("FAIL sector_pad: got %h want 0f", l_out_data);
                else passed++;
            end
            @(posedge clk_in);
            #1;
        end
        checks++;
        if (l_out_valid !== 1'b0) $display("FAIL sector_end: got v=%b want 0", l_out_valid);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_abort();
        test_random();
        test_async_reset();
        test_default_sector();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
